// File: rtl/out_sequencer.sv
// ----------------------------------------------------------------------------
// out_sequencer
//
// Takes one decoder result (code select, decoder fail flag, error count and
// packed error locations), sanity-checks it for one cycle, then streams the
// error locations out over a valid/ready port and closes the word with a
// one-cycle finish pulse carrying the word status.
//
// Configuration macro: OUT_SORT_EN
//   defined   : each beat carries the smallest not-yet-emitted location
//               (ascending order), found combinationally over the captured
//               slots.
//   undefined : slots are emitted in index order 0..cnt-1.
//
// Handshake: a beat transfers on a rising edge where o_out_valid=1 and
// i_out_ready=1. Once o_out_valid is raised it stays high, and o_out_loc
// stays constant, until that beat transfers. o_out_loc is 0 whenever
// o_out_valid is 0.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      one-cycle pulse, decode result ready (ignored unless idle)
//   i_code       0=len 63, 1=len 255, 2=len 1023, 3=reserved (always fails)
//   i_fail       decoder declared the word uncorrectable
//   i_err_cnt    number of valid slots
//   i_err_loc    packed slot locations, slot 0 in the LSBs
//   i_out_ready  sink accepts the current beat
//   o_out_valid  o_out_loc holds a location
//   o_out_loc    error location
//   o_finish     one-cycle end-of-word pulse
//   o_fail       word status, meaningful while o_finish=1
//   o_busy       word in progress (CHECK or EMIT)
// ----------------------------------------------------------------------------
module out_sequencer #(
   parameter int ERR_MAX = 4,
   parameter int LOC_W   = 10
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_start,
   input  logic [1:0]               i_code,
   input  logic                     i_fail,
   input  logic [2:0]               i_err_cnt,
   input  logic [ERR_MAX*LOC_W-1:0] i_err_loc,
   input  logic                     i_out_ready,
   output logic                     o_out_valid,
   output logic [LOC_W-1:0]         o_out_loc,
   output logic                     o_finish,
   output logic                     o_fail,
   output logic                     o_busy
);

   localparam int IDX_W = (ERR_MAX > 1) ? $clog2(ERR_MAX) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_EMIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Captured word
   logic [1:0]       code_q;
   logic             fail_in_q;
   logic [2:0]       cnt_q;
   logic [LOC_W-1:0] loc_q [ERR_MAX];
   logic [ERR_MAX-1:0] used_q;
   logic [2:0]       emit_cnt_q;
   logic             fail_q;

   // Output registers
   logic             out_valid_q;
   logic [LOC_W-1:0] out_loc_q;
   logic             finish_q;
   logic             out_fail_q;

   // FSM control strobes
   logic             capture;
   logic             load_beat;
   logic             go_done;

   // Check and selection results
   logic             check_fail;
   logic [IDX_W-1:0] sel_idx;
   logic [LOC_W-1:0] sel_loc;
   logic             sel_found;

   // ------------------------------------------------------------------------
   // Word check, evaluated over the captured registers while in CHECK.
   // ------------------------------------------------------------------------
   always_comb begin
      int code_len;
      check_fail = 1'b0;
      code_len   = 0;
      case (code_q)
         2'd0:    code_len = 63;
         2'd1:    code_len = 255;
         2'd2:    code_len = 1023;
         default: code_len = 0;
      endcase
      if (fail_in_q || (code_q == 2'd3) || (int'(cnt_q) > ERR_MAX)) begin
         check_fail = 1'b1;
      end
      for (int i = 0; i < ERR_MAX; i++) begin
         if (i < int'(cnt_q)) begin
            if (int'(loc_q[i]) >= code_len) begin
               check_fail = 1'b1;
            end
            for (int j = i + 1; j < ERR_MAX; j++) begin
               if ((j < int'(cnt_q)) && (loc_q[i] == loc_q[j])) begin
                  check_fail = 1'b1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-slot selection among the valid, not-yet-used slots.
   // ------------------------------------------------------------------------
   always_comb begin
      sel_idx   = '0;
      sel_loc   = '0;
      sel_found = 1'b0;
      for (int i = 0; i < ERR_MAX; i++) begin
         if ((i < int'(cnt_q)) && !used_q[i]) begin
`ifdef OUT_SORT_EN
            // Running minimum; strict '<' keeps the lower index on ties,
            // although ties never reach EMIT because duplicates fail CHECK.
            if (!sel_found || (loc_q[i] < sel_loc)) begin
               sel_found = 1'b1;
               sel_idx   = IDX_W'(i);
               sel_loc   = loc_q[i];
            end
`else
            // Lowest unused index: plain index order.
            if (!sel_found) begin
               sel_found = 1'b1;
               sel_idx   = IDX_W'(i);
               sel_loc   = loc_q[i];
            end
`endif
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and control strobes.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      load_beat = 1'b0;
      go_done   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               capture = 1'b1;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (check_fail || (cnt_q == 3'd0)) begin
               go_done = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            // The first EMIT cycle only loads the output register; afterwards
            // each accepted beat either reloads it or closes the word.
            if (!out_valid_q) begin
               load_beat = sel_found;
            end else if (i_out_ready) begin
               if (emit_cnt_q == cnt_q) begin
                  go_done = 1'b1;
                  state_d = S_DONE;
               end else begin
                  load_beat = sel_found;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, captured word and output registers.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         code_q      <= '0;
         fail_in_q   <= 1'b0;
         cnt_q       <= '0;
         for (int i = 0; i < ERR_MAX; i++) begin
            loc_q[i] <= '0;
         end
         used_q      <= '0;
         emit_cnt_q  <= '0;
         fail_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_loc_q   <= '0;
         finish_q    <= 1'b0;
         out_fail_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         finish_q   <= go_done;
         out_fail_q <= go_done && ((state_q == S_CHECK) ? check_fail : fail_q);

         if (capture) begin
            code_q     <= i_code;
            fail_in_q  <= i_fail;
            cnt_q      <= i_err_cnt;
            for (int i = 0; i < ERR_MAX; i++) begin
               loc_q[i] <= i_err_loc[i*LOC_W +: LOC_W];
            end
            used_q     <= '0;
            emit_cnt_q <= '0;
            fail_q     <= 1'b0;
         end

         if (state_q == S_CHECK) begin
            fail_q <= check_fail;
         end

         if (load_beat) begin
            out_valid_q      <= 1'b1;
            out_loc_q        <= sel_loc;
            used_q[sel_idx]  <= 1'b1;
            emit_cnt_q       <= emit_cnt_q + 3'd1;
         end else if (out_valid_q && i_out_ready) begin
            out_valid_q <= 1'b0;
            out_loc_q   <= '0;
         end
      end
   end

   assign o_out_valid = out_valid_q;
   assign o_out_loc   = out_loc_q;
   assign o_finish    = finish_q;
   assign o_fail      = out_fail_q;
   assign o_busy      = (state_q == S_CHECK) || (state_q == S_EMIT);

endmodule
